// File: rtl/sev_seg_scheduler.sv
// sev_seg_scheduler
// ------------------------------------------------------------------
// Display scheduler for the ATM seven-segment bank. It runs the 8-digit
// scan and shares the display between three requesters: alert, PIN entry
// and balance. Ownership and the displayed data only change at a frame
// boundary, which is the edge where the digit counter wraps 7->0, so a
// frame never mixes two sources or two data values.
//
// Ports
//   sclk_1ms    in   1   scan clock, one digit slot per cycle
//   rst         in   1   asynchronous, active-high reset
//   alert_req   in   1   alert requests the display (level)
//   alert_data  in  32   nibble i is the code for digit i
//   pin_req     in   1   PIN entry requests the display (level)
//   pin_len     in   4   PIN digits entered (values above 8 count as 8)
//   bal_req     in   1   balance requests the display (level)
//   bal_data    in  32   8 BCD digits, nibble 0 least significant
//   led_bcd     out  4   code for the current digit (0-9, A dash, F blank)
//   led_select  out  3   index of the current digit
//   grant       out  2   owner: 00 idle, 01 balance, 10 PIN, 11 alert
//   frame_done  out  1   high while led_select==7
//
// Request semantics: the req inputs are plain levels with no handshake.
// A source holds its req high for as long as it wants the display; the
// scheduler samples the levels only at frame boundaries and reports the
// result on grant. There is no acknowledge and no data-valid qualifier:
// the owner's data is captured at the boundary on which it is granted and
// on every following boundary while it stays the owner.
//
// grant is also the arbitration state register and serves as its
// debug view.
// ------------------------------------------------------------------
module sev_seg_scheduler #(
  parameter int MIN_HOLD_MS = 2000,
  parameter int BLINK_MS    = 500
) (
  input  logic        sclk_1ms,
  input  logic        rst,
  input  logic        alert_req,
  input  logic [31:0] alert_data,
  input  logic        pin_req,
  input  logic [3:0]  pin_len,
  input  logic        bal_req,
  input  logic [31:0] bal_data,
  output logic [3:0]  led_bcd,
  output logic [2:0]  led_select,
  output logic [1:0]  grant,
  output logic        frame_done
);

  localparam int HOLD_W  = $clog2(MIN_HOLD_MS + 1);
  localparam int BLINK_W = $clog2(BLINK_MS + 1);

  localparam logic [1:0] G_IDLE  = 2'b00;
  localparam logic [1:0] G_BAL   = 2'b01;
  localparam logic [1:0] G_PIN   = 2'b10;
  localparam logic [1:0] G_ALERT = 2'b11;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Registered state
  logic [2:0]         sel_q;
  logic [1:0]         grant_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_on_q;
  logic [31:0]        fbuf_q;
  logic [3:0]         led_bcd_q;
  logic               frame_done_q;

  // Next-state values
  logic [2:0]         sel_d;
  logic [1:0]         grant_d;
  logic [HOLD_W-1:0]  hold_d;
  logic [BLINK_W-1:0] blink_cnt_d;
  logic               blink_on_d;
  logic [31:0]        fbuf_d;
  logic [3:0]         led_bcd_d;
  logic               frame_done_d;

  logic               boundary;
  logic [1:0]         top_req;
  logic               owner_req;

  // Code for digit d of a frame owned by g holding data fb.
  function automatic logic [3:0] render(input logic [1:0]  g,
                                        input logic [31:0] fb,
                                        input logic [2:0]  d,
                                        input logic        on);
    logic [3:0] nib;
    logic [3:0] len;
    logic       upper_zero;
    logic [3:0] code;
    nib = fb[{d, 2'b00} +: 4];
    len = (fb[3:0] > 4'd8) ? 4'd8 : fb[3:0];
    // True when digit d and every digit above it are zero, i.e. d lies
    // in the leading-zero run. Non-BCD nibbles count as nonzero here.
    upper_zero = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k >= int'(d) && fb[k*4 +: 4] != 4'd0) upper_zero = 1'b0;
    end
    code = CODE_BLANK;
    case (g)
      G_BAL: begin
        if (d != 3'd0 && upper_zero) code = CODE_BLANK;
        else if (nib > 4'd9)         code = CODE_BLANK;
        else                         code = nib;
      end
      G_PIN:   code = ({1'b0, d} < len) ? CODE_DASH : CODE_BLANK;
      G_ALERT: code = on ? nib : CODE_BLANK;
      default: code = CODE_BLANK;
    endcase
    return code;
  endfunction

  // State register
  always_ff @(posedge sclk_1ms or posedge rst) begin
    if (rst) begin
      sel_q        <= 3'd0;
      grant_q      <= G_IDLE;
      hold_q       <= '0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      fbuf_q       <= 32'd0;
      led_bcd_q    <= CODE_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      grant_q      <= grant_d;
      hold_q       <= hold_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      fbuf_q       <= fbuf_d;
      led_bcd_q    <= led_bcd_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic: scan counter, arbitration, hold, blink, frame buffer
  always_comb begin
    sel_d    = sel_q + 3'd1;
    boundary = (sel_q == 3'd7);

    if (alert_req)    top_req = G_ALERT;
    else if (pin_req) top_req = G_PIN;
    else if (bal_req) top_req = G_BAL;
    else              top_req = G_IDLE;

    case (grant_q)
      G_BAL:   owner_req = bal_req;
      G_PIN:   owner_req = pin_req;
      G_ALERT: owner_req = alert_req;
      default: owner_req = 1'b0;
    endcase

    // Encodings are ordered by priority, so a numeric compare is a
    // priority compare; idle (00) loses to every requester.
    grant_d = grant_q;
    if (boundary) begin
      if (top_req > grant_q)                   grant_d = top_req;
      else if (!owner_req && hold_q == '0)     grant_d = top_req;
    end

    if (grant_d != grant_q && grant_d != G_IDLE) hold_d = HOLD_W'(MIN_HOLD_MS - 1);
    else if (hold_q != '0)                       hold_d = hold_q - HOLD_W'(1);
    else                                         hold_d = hold_q;

    // Blink phase only runs while alert owns the display; a fresh alert
    // grant always starts with a full on-phase.
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (grant_d == G_ALERT && grant_q != G_ALERT) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (grant_d == G_ALERT) begin
      if (blink_cnt_q == BLINK_W'(BLINK_MS - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end else begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end

    fbuf_d = fbuf_q;
    if (boundary) begin
      case (grant_d)
        G_ALERT: fbuf_d = alert_data;
        G_PIN:   fbuf_d = {28'd0, pin_len};
        G_BAL:   fbuf_d = bal_data;
        default: fbuf_d = 32'd0;
      endcase
    end
  end

  // Output logic: the code is rendered from next-state values so that the
  // registered led_bcd always matches the registered led_select, including
  // digit 0 of a newly granted owner.
  always_comb begin
    led_bcd_d    = render(grant_d, fbuf_d, sel_d, blink_on_d);
    frame_done_d = (sel_d == 3'd7);
  end

  assign led_bcd    = led_bcd_q;
  assign led_select = sel_q;
  assign grant      = grant_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sev_seg_scheduler.sv
// Testbench for sev_seg_scheduler, built with MIN_HOLD_MS=16 and BLINK_MS=8.
// Table-driven single-owner frames plus hand sequences for reset, scan,
// preemption/hold, blink and mid-frame data changes.
module tb_sev_seg_scheduler;

  logic        sclk_1ms;
  logic        rst;
  logic        alert_req;
  logic [31:0] alert_data;
  logic        pin_req;
  logic [3:0]  pin_len;
  logic        bal_req;
  logic [31:0] bal_data;
  logic [3:0]  led_bcd;
  logic [2:0]  led_select;
  logic [1:0]  grant;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  sev_seg_scheduler #(.MIN_HOLD_MS(16), .BLINK_MS(8)) dut (
    .sclk_1ms  (sclk_1ms),
    .rst       (rst),
    .alert_req (alert_req),
    .alert_data(alert_data),
    .pin_req   (pin_req),
    .pin_len   (pin_len),
    .bal_req   (bal_req),
    .bal_data  (bal_data),
    .led_bcd   (led_bcd),
    .led_select(led_select),
    .grant     (grant),
    .frame_done(frame_done)
  );

  // Clock / reset
  initial sclk_1ms = 1'b0;
  always #5 sclk_1ms = ~sclk_1ms;

  typedef struct {
    logic        a_req;
    logic        p_req;
    logic        b_req;
    logic [31:0] a_data;
    logic [3:0]  p_len;
    logic [31:0] b_data;
    logic [1:0]  exp_grant;
    logic [31:0] exp_frame;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_inputs(input logic a, input logic p, input logic b,
                            input logic [31:0] ad, input logic [3:0] pl, input logic [31:0] bd);
    alert_req = a; pin_req = p; bal_req = b;
    alert_data = ad; pin_len = pl; bal_data = bd;
  endtask

  // Called at a negedge; applies a synchronous-looking reset pulse and
  // returns at a negedge with the scanner sitting at digit 0.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge sclk_1ms);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where led_select==v.
  task automatic wait_sel(input logic [2:0] v);
    int n;
    n = 0;
    while (led_select !== v && n < 16) begin
      @(negedge sclk_1ms);
      n++;
    end
    if (led_select !== v) begin
      checks++;
      errors++;
      $display("FAIL wait_sel timeout: led_select %h expected %h", led_select, v);
    end
  endtask

  // Reads one full frame starting at the next digit 0; returns at the
  // negedge where led_select==7. Nibble i of f is digit i.
  task automatic capture_frame(output logic [31:0] f, output logic [1:0] g);
    wait_sel(3'd0);
    g = grant;
    f = 32'd0;
    for (int d = 0; d < 8; d++) begin
      f[d*4 +: 4] = led_bcd;
      if (d < 7) @(negedge sclk_1ms);
    end
  endtask

  // Scoreboard for the blink sequence
  logic [31:0] exp_q[$];

  logic [31:0] frame;
  logic [1:0]  g;

  initial begin
    rst = 1'b1;
    set_inputs(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

    // ---------------- directed vectors ----------------
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h0, 4'd0, 32'h00012345, 2'b01, 32'hFFF12345};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0, 4'd0, 32'h00000000, 2'b01, 32'hFFFFFFF0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0, 4'd0, 32'h0A000000, 2'b01, 32'hFF000000};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0, 4'd0, 32'h90000001, 2'b01, 32'h90000001};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0, 4'd3, 32'h0,        2'b10, 32'hFFFFFAAA};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0, 4'd12, 32'h0,       2'b10, 32'hAAAAAAAA};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0, 4'd0, 32'h0,        2'b10, 32'hFFFFFFFF};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0, 4'd8, 32'h0,        2'b10, 32'hAAAAAAAA};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h87654321, 4'd0, 32'h0, 2'b11, 32'h87654321};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'hFEDCBA98, 4'd5, 32'h12, 2'b11, 32'hFEDCBA98};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h0, 4'd1, 32'h00000099, 2'b10, 32'hFFFFFFFA};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h11111111, 4'd4, 32'h5, 2'b00, 32'hFFFFFFFF};

    // ---------------- reset values ----------------
    @(negedge sclk_1ms);
    @(negedge sclk_1ms);
    check("reset led_select", 32'(led_select), 32'd0);
    check("reset led_bcd", 32'(led_bcd), 32'hF);
    check("reset grant", 32'(grant), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // ---------------- scan counter and frame_done ----------------
    for (int i = 0; i < 16; i++) begin
      check("scan led_select", 32'(led_select), 32'(i % 8));
      check("scan frame_done", 32'(frame_done), 32'((i % 8) == 7));
      @(negedge sclk_1ms);
    end

    // ---------------- table-driven single-owner frames ----------------
    foreach (vecs[i]) begin
      do_reset();
      set_inputs(vecs[i].a_req, vecs[i].p_req, vecs[i].b_req,
                 vecs[i].a_data, vecs[i].p_len, vecs[i].b_data);
      @(negedge sclk_1ms);
      capture_frame(frame, g);
      check($sformatf("vec%0d grant", i), 32'(g), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d frame", i), frame, vecs[i].exp_frame);
    end

    // ---------------- asynchronous reset mid-frame ----------------
    do_reset();
    set_inputs(1'b0, 1'b0, 1'b1, 32'h0, 4'd0, 32'h00012345);
    @(negedge sclk_1ms);
    wait_sel(3'd0);
    check("pre-reset grant", 32'(grant), 32'd1);
    wait_sel(3'd4);
    #1 rst = 1'b1;
    #1;
    check("async reset led_select", 32'(led_select), 32'd0);
    check("async reset led_bcd", 32'(led_bcd), 32'hF);
    check("async reset grant", 32'(grant), 32'd0);
    @(negedge sclk_1ms);
    rst = 1'b0;
    @(negedge sclk_1ms);
    check("restart led_select", 32'(led_select), 32'd1);

    // ---------------- preemption and hold ----------------
    do_reset();
    set_inputs(1'b0, 1'b0, 1'b1, 32'h0, 4'd0, 32'h00012345);
    @(negedge sclk_1ms);
    wait_sel(3'd0);
    check("preempt bal owner", 32'(grant), 32'd1);
    wait_sel(3'd3);
    alert_req  = 1'b1;
    alert_data = 32'h87654321;
    for (int s = 4; s < 8; s++) begin
      @(negedge sclk_1ms);
      check($sformatf("preempt not early sel%0d", s), 32'(grant), 32'd1);
    end
    @(negedge sclk_1ms);
    check("preempt grant alert", 32'(grant), 32'd3);
    check("preempt digit0 alert", 32'(led_bcd), 32'h1);
    alert_req = 1'b0;
    repeat (8) @(negedge sclk_1ms);
    check("hold keeps alert", 32'(led_select), 32'd0);
    check("hold keeps alert grant", 32'(grant), 32'd3);
    repeat (8) @(negedge sclk_1ms);
    check("release to bal grant", 32'(grant), 32'd1);
    capture_frame(frame, g);
    check("release bal frame", frame, 32'hFFF12345);

    // ---------------- blink ----------------
    do_reset();
    set_inputs(1'b1, 1'b0, 1'b0, 32'h87654321, 4'd0, 32'h0);
    exp_q.push_back(32'h87654321);
    exp_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'h87654321);
    exp_q.push_back(32'hFFFFFFFF);
    @(negedge sclk_1ms);
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      @(negedge sclk_1ms);
      capture_frame(frame, g);
      check("blink grant", 32'(g), 32'd3);
      check("blink frame", frame, e);
    end

    // ---------------- no tearing ----------------
    do_reset();
    set_inputs(1'b0, 1'b0, 1'b1, 32'h0, 4'd0, 32'h00012345);
    @(negedge sclk_1ms);
    wait_sel(3'd0);
    wait_sel(3'd3);
    bal_data = 32'h00098765;
    frame = 32'd0;
    for (int d = 3; d < 8; d++) begin
      frame[d*4 +: 4] = led_bcd;
      if (d < 7) @(negedge sclk_1ms);
    end
    check("tear old digits 3-7", frame[31:12], 20'hFFF12);
    @(negedge sclk_1ms);
    capture_frame(frame, g);
    check("tear new frame", frame, 32'hFFF98765);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/sev_seg_scheduler.md
# sev_seg_scheduler

Display scheduler for the ATM seven-segment bank. It owns the 8-digit scan sequence that drives the segment decoder/digit control, and shares the display between three requesters: alert, PIN entry and balance. It latches one requester's data per scan frame, so digits never tear mid-frame. It also applies per-source rendering: leading-zero suppression, PIN masking and alert blinking. It runs in the 1 ms scan-clock domain and emits one 4-bit code plus digit index per cycle.

## Interface
- MIN_HOLD_MS, 2000: minimum cycles a granted source keeps the display before an equal- or lower-priority switch.
- BLINK_MS, 500: alert on/off half-period in cycles.
- sclk_1ms  in  1  scan clock, one digit slot per cycle.
- rst  in  1  reset, asynchronous, active-high.
- alert_req  in  1  alert source requests the display (level).
- alert_data  in  32  8 nibble codes; nibble i is digit i.
- pin_req  in  1  PIN-entry source requests the display (level).
- pin_len  in  4  number of PIN digits entered; values above 8 clamp to 8.
- bal_req  in  1  balance source requests the display (level).
- bal_data  in  32  8 BCD digits; nibble 0 is the least-significant digit.
- led_bcd  out  4  code for the current digit: 0-9 digit, 4'hA dash, 4'hF blank.
- led_select  out  3  index of the current digit, 0-7.
- grant  out  2  current owner: 00 idle, 01 balance, 10 PIN, 11 alert.
- frame_done  out  1  one-cycle pulse while led_select==7.

## Operation
- **Scan counter**
  - 3-bit digit counter increments every cycle and wraps 7->0.
  - led_select is the counter value.
  - The frame boundary is the edge on which the counter wraps 7->0.
- **Arbitration** is evaluated only at a frame boundary, on the req levels sampled at that edge. Priority is alert > PIN > balance.
  - Preemption: if a source of strictly higher priority than the owner requests, it is granted regardless of the hold counter.
  - Release: if the owner's req is low and the hold counter is 0, grant goes to the highest requester, or to idle if there is none.
  - Otherwise the owner is kept, including when the owner's req is low but hold is still nonzero.
- **Hold counter**
  - Loads MIN_HOLD_MS-1 on any grant change to a non-idle owner.
  - Otherwise decrements each cycle, saturating at 0.
- **Frame buffer**
  - At every frame boundary, the new owner's data (alert_data, bal_data or pin_len) is latched.
  - Input changes mid-frame do not affect the current frame.
- **Rendering per owner**
  - Idle: every digit 4'hF.
  - Balance:
    - Digits 7..1 that are zero and lie above the most-significant nonzero digit show 4'hF.
    - Digit 0 is always shown.
    - Nibbles >9 are output as 4'hF.
  - PIN: digit i shows 4'hA if i < clamped pin_len, else 4'hF.
  - Alert:
    - Nibbles pass through unchanged during the on-phase.
    - All digits show 4'hF during the off-phase.
- **Blink**
  - A counter toggles the phase every BLINK_MS cycles while alert is granted.
  - On grant to alert, the phase is forced to on and the counter cleared.
- **Reset mid-operation**
  - Everything returns to reset values immediately.
  - Scanning restarts at digit 0 after rst falls.

## Timing
- **Reset values:** led_select=0, led_bcd=4'hF, grant=00, frame_done=0, hold=0, blink phase on, frame buffer 0.
- **Registered outputs:**
  - led_bcd, led_select, grant and frame_done are all registered.
  - led_bcd always corresponds to the led_select value of the same cycle.
- **Grant timing:**
  - A new grant and the digit-0 code of the new owner appear on the same edge as led_select returns to 0.
  - Request-to-display latency is 1-8 cycles.
- **frame_done** is high exactly 1 cycle out of every 8.
- **Simultaneous requests at a boundary:** highest priority wins, and lower requests wait.
- **Owner drops req and a higher source asserts on the same boundary:** the higher source is granted (preemption path).

## Test plan
- **Reset:** assert rst mid-frame -> led_select=0, led_bcd=F and grant=00 asynchronously; after release, led_select cycles 0..7 and frame_done pulses every 8 cycles.
- **Leading-zero suppression:** bal_req=1, bal_data=32'h00012345 -> grant=01 at the next boundary; digits 0-7 show 5,4,3,2,1,F,F,F. With bal_data=0, digit 0 shows 0 and the rest F.
- **PIN masking:** pin_req=1, pin_len=3 -> digits 0-2 show A, 3-7 show F; pin_len=12 -> all 8 digits show A.
- **Preemption and hold:**
  - Balance owns the display; alert_req rises mid-frame -> grant=11 at the next boundary, not earlier.
  - Drop alert_req with MIN_HOLD_MS=16 -> alert keeps the display until hold reaches 0, then balance returns at the following boundary.
- **Blink:** alert granted with BLINK_MS=8, alert_data=32'h87654321 -> frames alternate between data and all-F every 8 cycles, starting with the on-phase.
- **No tearing:** change bal_data while led_select=3 -> the remaining digits of that frame still show the old value; the new value appears from the next digit 0.
